// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: byte FIFO feeding a start/data/parity/stop serializer
// that advances one bit per transmit_edge from the baud generator.
module uart_tx_ctrl #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     pclk,
    input  logic                     preset,
    input  logic [7:0]               wdata,
    input  logic                     wvalid,
    output logic                     wready,
    input  logic [1:0]               wls,
    input  logic                     stb,
    input  logic                     pen,
    input  logic                     eps,
    input  logic                     sp,
    input  logic                     brk,
    input  logic                     transmit_edge,
    output logic                     transmit_clk_clr,
    output logic                     txd,
    output logic                     tx_busy,
    output logic                     tx_done,
    output logic                     thre,
    output logic                     temt,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t          state, state_next;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wptr, rptr;
    logic [LW-1:0]   level;
    logic [7:0]      shifter;
    logic [2:0]      bit_cnt;
    logic            stop_cnt;
    logic            par;
    logic [1:0]      f_wls;
    logic            f_stb, f_pen, f_eps, f_sp;
    logic            txd_r, clr_r, done_r, busy_r;
    logic            bit_edge, last_data, last_stop, fifo_nempty, push, pop;
    logic            txd_next, clr_next, done_next, par_cur;

    // A bit edge coinciding with the counter restart belongs to the old count.
    assign bit_edge    = transmit_edge & ~clr_r;
    assign fifo_nempty = (level != '0);
    assign wready      = (level != LW'(DEPTH));
    assign push        = wvalid & wready;
    assign last_data   = (bit_cnt == ({1'b0, f_wls} + 3'd4));
    assign last_stop   = (stop_cnt == f_stb);

    assign thre             = ~fifo_nempty;
    assign temt             = ~fifo_nempty & (state == IDLE);
    assign fifo_level       = level;
    assign txd              = txd_r;
    assign transmit_clk_clr = clr_r;
    assign tx_done          = done_r;
    assign tx_busy          = busy_r;

    always_ff @(posedge pclk) begin
        if (preset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        unique case (state)
            IDLE: if (fifo_nempty) begin
                pop        = 1'b1;
                state_next = START;
            end
            START:  if (bit_edge) state_next = DATA;
            DATA:   if (bit_edge && last_data) state_next = f_pen ? PARITY : STOP;
            PARITY: if (bit_edge) state_next = STOP;
            STOP: if (bit_edge && last_stop) begin
                if (fifo_nempty) begin
                    pop        = 1'b1;
                    state_next = START;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // txd is registered, so it is computed for the bit that follows this edge.
    always_comb begin
        par_cur   = (state == DATA) ? (par ^ shifter[0]) : par;
        clr_next  = pop;
        done_next = (state == STOP) && bit_edge && last_stop;
        unique case (state_next)
            START:  txd_next = 1'b0;
            DATA:   txd_next = (state == DATA && bit_edge) ? shifter[1] : shifter[0];
            PARITY: txd_next = f_sp ? ~f_eps : (f_eps ? par_cur : ~par_cur);
            default: txd_next = 1'b1;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (push) mem[wptr] <= wdata;
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            wptr     <= '0;
            rptr     <= '0;
            level    <= '0;
            shifter  <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            par      <= 1'b0;
            f_wls    <= '0;
            f_stb    <= 1'b0;
            f_pen    <= 1'b0;
            f_eps    <= 1'b0;
            f_sp     <= 1'b0;
            txd_r    <= 1'b1;
            clr_r    <= 1'b0;
            done_r   <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            unique case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            if (bit_edge) begin
                unique case (state)
                    DATA: begin
                        shifter <= {1'b0, shifter[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        par     <= par ^ shifter[0];
                    end
                    STOP:    stop_cnt <= 1'b1;
                    default: ;
                endcase
            end
            if (pop) begin
                rptr     <= rptr + AW'(1);
                shifter  <= mem[rptr];
                bit_cnt  <= '0;
                stop_cnt <= 1'b0;
                par      <= 1'b0;
                f_wls    <= wls;
                f_stb    <= stb;
                f_pen    <= pen;
                f_eps    <= eps;
                f_sp     <= sp;
            end
            txd_r  <= brk ? 1'b0 : txd_next;
            clr_r  <= clr_next;
            done_r <= done_next;
            busy_r <= (state_next != IDLE);
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl with a 16-cycle-per-bit baud generator model.
module tb_uart_tx_ctrl;

    logic       pclk = 1'b0;
    logic       preset;
    logic [7:0] wdata;
    logic       wvalid;
    logic       wready;
    logic [1:0] wls;
    logic       stb, pen, eps, sp, brk;
    logic       transmit_edge = 1'b0;
    logic       transmit_clk_clr, txd, tx_busy, tx_done, thre, temt;
    logic [2:0] fifo_level;

    int checks = 0;
    int passed = 0;
    int done_cnt = 0;
    int clr_cnt = 0;
    int edge_cnt = 0;

    always #5 pclk = ~pclk;

    uart_tx_ctrl #(.DEPTH(4)) dut (
        .pclk(pclk), .preset(preset), .wdata(wdata), .wvalid(wvalid), .wready(wready),
        .wls(wls), .stb(stb), .pen(pen), .eps(eps), .sp(sp), .brk(brk),
        .transmit_edge(transmit_edge), .transmit_clk_clr(transmit_clk_clr), .txd(txd),
        .tx_busy(tx_busy), .tx_done(tx_done), .thre(thre), .temt(temt), .fifo_level(fifo_level)
    );

    // Baud generator: transmit_edge every 16 cycles after each counter clear.
    always @(negedge pclk) begin
        if (transmit_clk_clr === 1'b1) begin
            clr_cnt++;
            edge_cnt = 0;
        end else begin
            edge_cnt++;
        end
        if (tx_done === 1'b1) done_cnt++;
        transmit_edge = (edge_cnt % 16 == 15);
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation still running at 1ms, expected completion");
        $fatal(1);
    end

    task automatic push_byte(input logic [7:0] b);
        @(negedge pclk);
        wdata  = b;
        wvalid = 1'b1;
        @(negedge pclk);
        wvalid = 1'b0;
    endtask

    // Waits (bounded) for a start bit, then samples nbits bit centres; gap=-1 on timeout.
    task automatic capture_frame(input int nbits, output logic [15:0] got, output int gap);
        got = '0;
        gap = 0;
        while (txd !== 1'b0 && gap < 3000) begin
            @(negedge pclk);
            gap++;
        end
        if (gap >= 3000) begin
            gap = -1;
        end else begin
            repeat (8) @(negedge pclk);
            for (int i = 0; i < nbits; i++) begin
                got[i] = txd;
                repeat ((i == nbits - 1) ? 8 : 16) @(negedge pclk);
            end
        end
    endtask

    task automatic test_reset();
        preset = 1'b1;
        repeat (2) @(negedge pclk);
        preset = 1'b0;
        checks++; if (txd !== 1'b1) $display("FAIL reset_txd: got %b expected 1", txd); else passed++;
        checks++; if (wready !== 1'b1) $display("FAIL reset_wready: got %b expected 1", wready); else passed++;
        checks++; if (thre !== 1'b1) $display("FAIL reset_thre: got %b expected 1", thre); else passed++;
        checks++; if (temt !== 1'b1) $display("FAIL reset_temt: got %b expected 1", temt); else passed++;
        checks++; if (tx_busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", tx_busy); else passed++;
        checks++; if (fifo_level !== 3'd0) $display("FAIL reset_level: got %0d expected 0", fifo_level); else passed++;
        checks++; if (tx_done !== 1'b0) $display("FAIL reset_done: got %b expected 0", tx_done); else passed++;
        checks++; if (transmit_clk_clr !== 1'b0) $display("FAIL reset_clr: got %b expected 0", transmit_clk_clr); else passed++;
    endtask

    task automatic test_8n1();
        logic [15:0] got;
        int gap, d0, c0;
        wls = 2'd3; pen = 1'b0; stb = 1'b0; eps = 1'b0; sp = 1'b0;
        d0 = done_cnt; c0 = clr_cnt;
        push_byte(8'hA5);
        checks++; if (fifo_level !== 3'd1) $display("FAIL 8n1_push_level: got %0d expected 1", fifo_level); else passed++;
        checks++; if (txd !== 1'b1) $display("FAIL 8n1_pre_start_txd: got %b expected 1", txd); else passed++;
        @(negedge pclk);
        checks++; if (txd !== 1'b0) $display("FAIL 8n1_start_txd: got %b expected 0", txd); else passed++;
        checks++; if (transmit_clk_clr !== 1'b1) $display("FAIL 8n1_start_clr: got %b expected 1", transmit_clk_clr); else passed++;
        checks++; if (fifo_level !== 3'd0) $display("FAIL 8n1_pop_level: got %0d expected 0", fifo_level); else passed++;
        checks++; if (tx_busy !== 1'b1) $display("FAIL 8n1_busy: got %b expected 1", tx_busy); else passed++;
        capture_frame(10, got, gap);
        checks++; if (got !== 16'({1'b1, 8'hA5, 1'b0}) || gap != 0)
            $display("FAIL 8n1_frame: got %h gap %0d expected %h gap 0", got, gap, 16'({1'b1, 8'hA5, 1'b0}));
        else passed++;
        repeat (4) @(negedge pclk);
        checks++; if (done_cnt - d0 != 1) $display("FAIL 8n1_done_count: got %0d expected 1", done_cnt - d0); else passed++;
        checks++; if (clr_cnt - c0 != 1) $display("FAIL 8n1_clr_count: got %0d expected 1", clr_cnt - c0); else passed++;
        checks++; if (temt !== 1'b1) $display("FAIL 8n1_temt: got %b expected 1", temt); else passed++;
    endtask

    task automatic test_parity();
        logic [15:0] got;
        int gap, d0;
        d0 = done_cnt;
        wls = 2'd2; pen = 1'b1; eps = 1'b1; stb = 1'b1; sp = 1'b0;
        push_byte(8'h35);
        @(negedge pclk);
        // Changing config after the frame has started must not affect it.
        wls = 2'd3; pen = 1'b0; stb = 1'b0;
        capture_frame(11, got, gap);
        checks++; if (got !== 16'({2'b11, 1'b0, 7'h35, 1'b0}) || gap != 0)
            $display("FAIL 7e2_frame: got %h gap %0d expected %h gap 0", got, gap, 16'({2'b11, 1'b0, 7'h35, 1'b0}));
        else passed++;
        repeat (20) @(negedge pclk);
        wls = 2'd0; pen = 1'b1; sp = 1'b1; eps = 1'b1; stb = 1'b0;
        push_byte(8'h1F);
        capture_frame(8, got, gap);
        checks++; if (got !== 16'({1'b1, 1'b0, 5'h1F, 1'b0}) || gap < 0)
            $display("FAIL stick_frame: got %h gap %0d expected %h", got, gap, 16'({1'b1, 1'b0, 5'h1F, 1'b0}));
        else passed++;
        repeat (4) @(negedge pclk);
        checks++; if (done_cnt - d0 != 2) $display("FAIL parity_done_count: got %0d expected 2", done_cnt - d0); else passed++;
        sp = 1'b0; pen = 1'b0; wls = 2'd3;
    endtask

    task automatic test_back_to_back();
        logic [15:0] got[6];
        int gap[6];
        int d0, c0, maxl, idx, guard;
        bit saw_full, acc;
        wls = 2'd3; pen = 1'b0; stb = 1'b0; sp = 1'b0;
        d0 = done_cnt; c0 = clr_cnt;
        maxl = 0; saw_full = 0; idx = 1; guard = 0;
        fork
            begin
                wdata  = 8'd1;
                wvalid = 1'b1;
                while (idx <= 6 && guard < 3000) begin
                    acc = wready;
                    @(negedge pclk);
                    guard++;
                    if (int'(fifo_level) > maxl) maxl = int'(fifo_level);
                    if (fifo_level == 3'd4 && wready === 1'b0) saw_full = 1;
                    if (acc) begin
                        idx++;
                        wdata = 8'(idx);
                    end
                end
                wvalid = 1'b0;
            end
            begin
                for (int k = 0; k < 6; k++) capture_frame(10, got[k], gap[k]);
            end
        join
        checks++; if (maxl != 4 || !saw_full) $display("FAIL fifo_full: got max level %0d full %0d expected 4 1", maxl, saw_full); else passed++;
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (got[k] !== 16'({1'b1, 8'(k + 1), 1'b0}) || gap[k] < 0 || (k > 0 && gap[k] != 0))
                $display("FAIL b2b_frame%0d: got %h gap %0d expected %h gap 0", k, got[k], gap[k], 16'({1'b1, 8'(k + 1), 1'b0}));
            else passed++;
        end
        repeat (4) @(negedge pclk);
        checks++; if (done_cnt - d0 != 6) $display("FAIL b2b_done_count: got %0d expected 6", done_cnt - d0); else passed++;
        checks++; if (clr_cnt - c0 != 6) $display("FAIL b2b_clr_count: got %0d expected 6", clr_cnt - c0); else passed++;
        checks++; if (temt !== 1'b1) $display("FAIL b2b_temt: got %b expected 1", temt); else passed++;
    endtask

    task automatic test_break();
        int d0;
        bit all_low;
        wls = 2'd3; pen = 1'b0; stb = 1'b0;
        d0 = done_cnt;
        push_byte(8'hA5);
        @(negedge pclk);
        checks++; if (txd !== 1'b0) $display("FAIL brk_start: got %b expected 0", txd); else passed++;
        repeat (70) @(negedge pclk);
        brk = 1'b1;
        all_low = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge pclk);
            if (txd !== 1'b0) all_low = 0;
        end
        brk = 1'b0;
        checks++; if (!all_low) $display("FAIL brk_low: got txd high during break expected 0"); else passed++;
        repeat (14) @(negedge pclk);
        checks++; if (txd !== 1'b1) $display("FAIL brk_data5: got %b expected 1", txd); else passed++;
        repeat (48) @(negedge pclk);
        checks++; if (txd !== 1'b1) $display("FAIL brk_stop: got %b expected 1", txd); else passed++;
        repeat (8) @(negedge pclk);
        checks++; if (tx_done !== 1'b1) $display("FAIL brk_done_timing: got %b expected 1", tx_done); else passed++;
        repeat (4) @(negedge pclk);
        checks++; if (done_cnt - d0 != 1) $display("FAIL brk_done_count: got %0d expected 1", done_cnt - d0); else passed++;
    endtask

    task automatic test_reset_midframe();
        int d0, c0;
        bit saw_low;
        @(negedge pclk);
        wdata = 8'h11; wvalid = 1'b1;
        @(negedge pclk);
        wdata = 8'h22;
        @(negedge pclk);
        wdata = 8'h33;
        @(negedge pclk);
        wvalid = 1'b0;
        checks++; if (fifo_level !== 3'd2) $display("FAIL rst_mid_queued: got %0d expected 2", fifo_level); else passed++;
        repeat (40) @(negedge pclk);
        d0 = done_cnt; c0 = clr_cnt;
        preset = 1'b1;
        @(negedge pclk);
        preset = 1'b0;
        checks++; if (txd !== 1'b1) $display("FAIL rst_mid_txd: got %b expected 1", txd); else passed++;
        checks++; if (fifo_level !== 3'd0) $display("FAIL rst_mid_level: got %0d expected 0", fifo_level); else passed++;
        checks++; if (tx_busy !== 1'b0) $display("FAIL rst_mid_busy: got %b expected 0", tx_busy); else passed++;
        saw_low = 0;
        repeat (300) begin
            @(negedge pclk);
            if (txd !== 1'b1) saw_low = 1;
        end
        checks++; if (saw_low) $display("FAIL rst_mid_quiet: got txd low after reset expected idle"); else passed++;
        checks++; if (done_cnt != d0 || clr_cnt != c0)
            $display("FAIL rst_mid_no_frames: got done %0d clr %0d expected 0 0", done_cnt - d0, clr_cnt - c0);
        else passed++;
    endtask

    initial begin
        preset = 1'b1; wdata = '0; wvalid = 1'b0; wls = 2'd3;
        stb = 1'b0; pen = 1'b0; eps = 1'b0; sp = 1'b0; brk = 1'b0;
        test_reset();
        test_8n1();
        test_parity();
        test_back_to_back();
        test_break();
        test_reset_midframe();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

UART transmit controller that sequences the baud clock generator's transmit side. It buffers bytes from the register interface in a small FIFO, serializes each one as start/data/parity/stop bits on `txd`, and advances one bit per `transmit_edge` pulse. It restarts the generator's transmit counter with `transmit_clk_clr` at each frame start.

## Interface
- `DEPTH`, 4: holding FIFO depth in bytes; power of two, ≥2.
- `pclk` in 1: clock, all logic on the rising edge.
- `preset` in 1: synchronous, active-high reset.
- `wdata` in 8: byte to transmit.
- `wvalid` in 1: write request.
- `wready` out 1: FIFO not full; a push occurs only when `wvalid & wready`.
- `wls` in 2: word length = 5 + `wls` bits.
- `stb` in 1: 0 = one stop bit, 1 = two stop bits.
- `pen` in 1: parity enable.
- `eps` in 1: 1 = even parity, 0 = odd parity.
- `sp` in 1: stick parity.
- `brk` in 1: break; forces `txd` low.
- `transmit_edge` in 1: one-cycle pulse marking the end of each bit period.
- `transmit_clk_clr` out 1: one-cycle pulse that restarts the generator's transmit counter.
- `txd` out 1: serial output, idle high.
- `tx_busy` out 1: high when the FSM is not in IDLE.
- `tx_done` out 1: one-cycle pulse at the end of a frame's last stop bit.
- `thre` out 1: FIFO empty.
- `temt` out 1: `thre` & FSM in IDLE.
- `fifo_level` out $clog2(DEPTH)+1: number of bytes stored.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- **IDLE.** If `fifo_level`>0:
  - pop the head byte into the shifter;
  - latch `wls`/`stb`/`pen`/`eps`/`sp` for the frame;
  - go to START.
  - `transmit_edge` is ignored in IDLE.
- **START.** `txd`=0. On `transmit_edge`, go to DATA with bit count 0.
- **DATA.** `txd` = shifter[0], LSB first. On each `transmit_edge`, shift right and increment the count.
  - After 5+`wls` bits, go to PARITY if `pen`, else STOP.
- **PARITY.** Parity covers only the 5+`wls` data bits.
  - `sp`=1: bit = ~`eps`.
  - `sp`=0, `eps`=1: bit = XOR of the data bits.
  - `sp`=0, `eps`=0: bit = XNOR of the data bits.
  - On `transmit_edge`, go to STOP.
- **STOP.** `txd`=1 for 1+`stb` bit periods. On the final `transmit_edge`, pulse `tx_done`, then:
  - if the FIFO is non-empty, pop and go directly to START (no idle bits between frames);
  - otherwise go to IDLE.
- Frame length = 1 + (5+`wls`) + `pen` + (1+`stb`) bit periods.
- Configuration changes mid-frame affect only the next frame.
- **`brk`.** `txd` = 0 whenever `brk`=1. The FSM, FIFO and `tx_done` proceed unaffected. `txd` returns to its FSM value in the cycle after `brk` falls.
- **FIFO.** Circular buffer with `DEPTH` entries.
  - `wready` = (`fifo_level` != `DEPTH`) from the registered level. When full, a push is refused even if a pop happens in the same cycle.
  - Simultaneous push and pop when not full: level unchanged; pointers wrap modulo `DEPTH`.
  - Bytes in unused bits above the word length are ignored.
- **Reset.** While `preset`=1, and from any state or mid-frame, at the next edge:
  - FSM to IDLE, FIFO flushed, pointers 0;
  - `txd`=1, `wready`=1, `thre`=1, `temt`=1;
  - `tx_busy`=0, `tx_done`=0, `transmit_clk_clr`=0, `fifo_level`=0.

## Timing
- All outputs are registered except `wready`, `thre` and `temt`, which decode registered state.
- **Frame start.** If IDLE with level>0 at edge N, then at edge N+1:
  - the pop takes effect and `fifo_level` decrements;
  - state becomes START, `txd`=0, `transmit_clk_clr`=1 for exactly one cycle.
- **Back-to-back frames.** At the last stop `transmit_edge` edge, `txd` goes 0, `transmit_clk_clr` pulses and `tx_done` pulses, all in the same cycle.
- **Push latency.** A byte pushed into an empty FIFO while IDLE at edge N appears as `fifo_level`=1 after edge N. The frame starts at edge N+1, so `txd` goes low 2 cycles after the push cycle.
- **Bit timing.** Each `transmit_edge` changes `txd` at the following edge, so every bit lasts exactly one edge-to-edge interval.
- `transmit_edge` arriving in the same cycle as `transmit_clk_clr` is ignored.

## Test plan
- **Reset.** Hold `preset` for 2 cycles -> `txd`=1, `wready`=1, `thre`=1, `temt`=1, `tx_busy`=0, `fifo_level`=0. Bench edge model: `transmit_edge` every 16 cycles after each clr.
- **8N1.** `wls`=3, `pen`=0, `stb`=0, push 0xA5 -> `txd` sequence 0,1,0,1,0,0,1,0,1,1, 16 cycles each. One `transmit_clk_clr` pulse and one `tx_done` pulse; `temt`=1 afterwards.
- **7E2 and stick parity.**
  - `wls`=2, `pen`=1, `eps`=1, `stb`=1, push 0x35 -> 0,1,0,1,0,1,1,0, parity 0, stop 1,1 (11 bits total).
  - `wls`=0, `pen`=1, `sp`=1, `eps`=1, push 0x1F -> 0,1,1,1,1,1, parity 0, stop 1.
- **FIFO full / back-to-back.** `DEPTH`=4, `wvalid` held with bytes 0x01..0x06 -> `fifo_level` saturates at 4 with `wready`=0 and no bytes lost. All 6 frames go out in order with no idle bits between stop and start; `tx_done` pulses 6 times.
- **Break.** Raise `brk` in the middle of data bit 3 for 20 cycles -> `txd`=0 throughout, the frame still completes on schedule, `tx_done` pulses once.
- **Reset mid-frame.** Assert `preset` during DATA with 2 bytes queued -> next cycle `txd`=1, `fifo_level`=0, `tx_busy`=0. No further frames after release.
